ssd_scan_controller: RTL

Time-multiplexes the board's eight common-anode seven-segment digits from one 32-bit hex value, with a blanking gap between digits to prevent ghosting. Each digit has its own enable and decimal point. New values are double-buffered and applied only at frame boundaries, so the display never tears. It sits between game/score logic and the An0..An7 / Ca..Cg,Dp pins, replacing ad-hoc scan logic in top-level modules.

---
 rtl/ssd_scan_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ssd_scan_controller.sv
// Scans eight common-anode 7-segment digits from a double-buffered 32-bit hex value.
// Latency: outputs registered with no extra lag; a load reaches the pins in slot 0 SHOW after the next frame boundary.
// Backpressure: none; load is always accepted and a later load overwrites the pending set.
//
// Ports:
//   ClkPort, Reset_n         : clock, asynchronous active-low reset
//   digits/digit_en/dp_en    : display data, captured into the pending set on load
//   load                     : one-clock capture strobe
//   An, Cath                 : active-low anodes and {Ca..Cg,Dp} cathodes
//   frame_done               : one-clock pulse at the start of each new frame
module ssd_scan_controller #(
    parameter int DIGIT_CYCLES = 262144,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic        ClkPort,
    input  logic        Reset_n,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_en,
    input  logic        load,
    output logic [7:0]  An,
    output logic [7:0]  Cath,
    output logic        frame_done
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  en;
        logic [7:0]  dp;
    } disp_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    disp_t         active_q, active_d;
    disp_t         pending_q, pending_d;
    logic          pend_vld_q, pend_vld_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    cath_q, cath_d;
    logic          frame_done_q, frame_done_d;
    logic          boundary;
    logic [3:0]    nib;

    // abcdefg, active-low
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        idx_d        = idx_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q;
        boundary     = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                end
            end
            default: begin
                if (cnt_q == DIGIT_LAST) begin
                    cnt_d    = '0;
                    idx_d    = idx_q + 3'd1;
                    state_d  = ST_BLANK;
                    boundary = (idx_q == 3'd7);
                end
            end
        endcase

        frame_done_d = boundary;

        // The boundary consumes the old pending set; a coinciding load
        // refills pending afterwards and waits for the next boundary.
        if (boundary && pend_vld_q) begin
            active_d   = pending_q;
            pend_vld_d = 1'b0;
        end
        if (load) begin
            pending_d  = '{digits: digits, en: digit_en, dp: dp_en};
            pend_vld_d = 1'b1;
        end

        // Output flops are loaded from the next-state values so the pins
        // always reflect the current state/idx/cnt with no extra lag.
        nib    = active_d.digits[{idx_d, 2'b00} +: 4];
        an_d   = 8'hFF;
        cath_d = 8'hFF;
        if (state_d == ST_SHOW && active_d.en[idx_d]) begin
            an_d[idx_d] = 1'b0;
            cath_d      = {seg7(nib), ~active_d.dp[idx_d]};
        end
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            an_q         <= 8'hFF;
            cath_q       <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            an_q         <= an_d;
            cath_q       <= cath_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign An         = an_q;
    assign Cath       = cath_q;
    assign frame_done = frame_done_q;

endmodule
